bin_to_bcd_seq: RTL
===================

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameter BIN_W, default 17, binary input width (2..32).
REQ-002 Parameter DIGITS, default 6, BCD output digit count (1..10).
REQ-003 Parameter STEPS, default 1, double-dabble iterations per clock (1..BIN_W).
REQ-004 Parameter SIGNED, default 0; 1 = input is two's complement, output is sign + magnitude.
REQ-005 clk  input  1  clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  bin is valid.
REQ-008 in_ready  output  1  block can accept a new value.
REQ-009 bin  input  BIN_W  binary value to convert.
REQ-010 out_valid  output  1  result is valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 bcd  output  4*DIGITS  packed BCD result; digit 0 in bits [3:0].
REQ-013 neg  output  1  result is negative; constant 0 when SIGNED=0.
REQ-014 overflow  output  1  magnitude exceeded DIGITS digits.

Function
REQ-015 The FSM SHALL have three states: IDLE, CONV and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 An accept (in_valid && in_ready) SHALL capture the operand, clear the BCD accumulator and overflow, and enter CONV.
REQ-018 SIGNED=1: on accept, neg SHALL capture bin[BIN_W-1] and the operand SHALL be the magnitude, held in BIN_W bits unsigned; -2^(BIN_W-1) SHALL convert correctly.
REQ-019 The operand SHALL be zero-extended at the MSB end to N*STEPS bits, where N = ceil(BIN_W/STEPS).
REQ-020 Each CONV cycle SHALL do STEPS iterations, MSB first; each iteration adds 3 to every digit >= 5, then shifts the next operand bit into digit 0.
REQ-021 CONV SHALL last exactly N cycles, counted by an iteration counter, then enter DONE.
REQ-022 The accept-to-out_valid latency SHALL be N+1 cycles; with the defaults this is 18.
REQ-023 If an iteration shifts a 1 out of the top digit, overflow SHALL be set and held until the next accept; the bcd digits SHALL keep the truncated low digits.
REQ-024 In DONE, out_valid SHALL be 1, and bcd, neg and overflow SHALL stay stable until out_ready is 1.
REQ-025 DONE && out_ready SHALL return the FSM to IDLE on the next cycle, with out_valid low; a new operand is accepted no earlier than that cycle.
REQ-026 in_valid and bin SHALL be ignored outside IDLE.
REQ-027 out_valid SHALL be 0 in IDLE and CONV.

Reset
REQ-028 reset SHALL force IDLE, clear the accumulator and the counter, and drive out_valid=0, bcd=0, neg=0, overflow=0 and in_ready=1 once reset is released.
REQ-029 A reset during CONV or DONE SHALL abandon the conversion with no output produced.
REQ-030 The first accept after reset SHALL be possible on the first rising edge with reset low.

Structure
REQ-031 Package bcd_pkg SHALL hold the state enum, a constant function for ceil-division, and the digit-correction (add-3) function.
REQ-032 Sub-module bcd_dabble_step SHALL be one combinational correct-and-shift iteration (inputs: accumulator, bit; outputs: accumulator, carry-out); it SHALL be instantiated STEPS times in a chain.
REQ-033 Elaboration SHALL fail on any parameter outside its range.

Verification
REQ-034 Defaults, bin=0 -> bcd=0x000000, overflow=0, out_valid in cycle 18 after accept.
REQ-035 Defaults, bin=131071 -> bcd=0x131071, overflow=0; then bin=99999 -> bcd=0x099999.
REQ-036 STEPS=4, bin=12345 -> bcd=0x012345, out_valid 6 cycles after accept (N=5).
REQ-037 SIGNED=1, BIN_W=8, DIGITS=3: bin=0x80 -> neg=1, bcd=0x128; bin=0x7F -> neg=0, bcd=0x127.
REQ-038 DIGITS=2, bin=100 -> overflow=1, bcd=0x00; out_ready held low 5 cycles -> outputs stable, in_ready=0 throughout.
REQ-039 reset pulsed in CONV cycle 5 -> out_valid never asserts, in_ready=1 after release; next bin=42 -> bcd=0x000042.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Ceiling division, usable in localparam expressions.
    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Double-dabble digit correction: digits >= 5 get +3 so the next
    // left shift carries correctly into the following decade.
    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational double-dabble iteration: correct every digit, then
// shift the incoming operand bit into digit 0.
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int DIGITS = 6
) (
    input  logic [4*DIGITS-1:0] acc_i,
    input  logic                bit_i,
    output logic [4*DIGITS-1:0] acc_o,
    output logic                carry_o
);

    logic [4*DIGITS-1:0] corr;

    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
        assign corr[4*d +: 4] = add3(acc_i[4*d +: 4]);
    end

    // The bit leaving the top digit is the overflow indication.
    assign acc_o   = {corr[4*DIGITS-2:0], bit_i};
    assign carry_o = corr[4*DIGITS-1];

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), STEPS iterations per
// clock, optional two's complement input reported as sign + magnitude.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 17,
    parameter int DIGITS = 6,
    parameter int STEPS  = 1,
    parameter int SIGNED = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BIN_W-1:0]    bin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] bcd,
    output logic                neg,
    output logic                overflow
);

    localparam int N     = ceil_div(BIN_W, STEPS);
    localparam int NS    = N * STEPS;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int AW    = 4 * DIGITS;

    if (BIN_W < 2 || BIN_W > 32) begin : g_bad_bin_w
        $error("bin_to_bcd_seq: BIN_W out of range 2..32");
    end
    if (DIGITS < 1 || DIGITS > 10) begin : g_bad_digits
        $error("bin_to_bcd_seq: DIGITS out of range 1..10");
    end
    if (STEPS < 1 || STEPS > BIN_W) begin : g_bad_steps
        $error("bin_to_bcd_seq: STEPS out of range 1..BIN_W");
    end
    if (SIGNED != 0 && SIGNED != 1) begin : g_bad_signed
        $error("bin_to_bcd_seq: SIGNED must be 0 or 1");
    end

    state_e               state_q, state_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [NS-1:0]        opnd_q, opnd_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic                 ovf_q, ovf_d;

    logic [BIN_W-1:0]     mag;
    logic [STEPS:0][AW-1:0] acc_chain;
    logic [STEPS-1:0]     carry;

    // Magnitude of the operand; -2^(BIN_W-1) wraps to 2^(BIN_W-1), which
    // is exactly right when read as unsigned.
    always_comb begin
        mag = bin;
        if (SIGNED != 0 && bin[BIN_W-1]) begin
            mag = (~bin) + {{(BIN_W-1){1'b0}}, 1'b1};
        end
    end

    // STEPS iterations chained combinationally, operand consumed MSB first.
    assign acc_chain[0] = acc_q;
    for (genvar s = 0; s < STEPS; s++) begin : g_step
        bcd_dabble_step #(.DIGITS(DIGITS)) u_step (
            .acc_i   (acc_chain[s]),
            .bit_i   (opnd_q[NS-1-s]),
            .acc_o   (acc_chain[s+1]),
            .carry_o (carry[s])
        );
    end

    // State register and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic: accept in IDLE, N iteration cycles, hold in DONE.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_CONV;
                    acc_d   = '0;
                    opnd_d  = NS'(mag);
                    cnt_d   = '0;
                    neg_d   = (SIGNED != 0) && bin[BIN_W-1];
                    ovf_d   = 1'b0;
                end
            end
            ST_CONV: begin
                acc_d  = acc_chain[STEPS];
                opnd_d = opnd_q << STEPS;
                ovf_d  = ovf_q | (|carry);
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N-1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign bcd       = acc_q;
    assign neg       = (SIGNED != 0) ? neg_q : 1'b0;
    assign overflow  = ovf_q;

endmodule
